// File: rtl/ex_stage_ctrl_pkg.sv
// rtl/ex_stage_ctrl_pkg.sv - shared widths and FSM encoding for the execute-stage controller
package ex_stage_ctrl_pkg;
  localparam int DATA_W     = 32;
  localparam int ALU_CTRL_W = 6;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ex_mc_counter.sv
// rtl/ex_mc_counter.sv - multi-cycle countdown: load, decrement to zero, zero flag
module ex_mc_counter
  import ex_stage_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/ex_stage_ctrl.sv
// rtl/ex_stage_ctrl.sv - execute-stage op sequencer between decode, an external ALU and writeback
// Multi-cycle ops are honoured only when EX_STAGE_CTRL_MULTICYCLE_EN is defined.
module ex_stage_ctrl
  import ex_stage_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [DATA_W-1:0]     d_pc,
  input  logic [ALU_CTRL_W-1:0] d_alu_ctrl,
  input  logic [DATA_W-1:0]     d_op_a,
  input  logic [DATA_W-1:0]     d_op_b,
  input  logic                  d_is_branch,
  input  logic                  d_multicycle,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0]     alu_op_a_o,
  output logic [DATA_W-1:0]     alu_op_b_o,
  output logic                  alu_is_branch_o,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic                  alu_br_en_i,
  output logic                  a_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     a_pc_o,
  output logic [DATA_W-1:0]     a_result,
  output logic                  a_br_en,
  input  logic                  flush,
  output logic                  busy
);
  state_t           state;
  logic [DATA_W-1:0] op_pc;
  logic             accept;
  logic             cnt_zero;

  assign d_ready = ((state == IDLE) || (state == DONE && w_ready)) && !flush;
  assign accept  = d_valid && d_ready;
  assign a_valid = (state == DONE);
  assign busy    = (state != IDLE);

`ifdef EX_STAGE_CTRL_MULTICYCLE_EN
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 1);

  ex_mc_counter u_mc_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .load     (accept),
    .load_val (d_multicycle ? MC_LOAD : '0),
    .dec      (state == EXEC),
    .zero     (cnt_zero)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{d_multicycle, 4'(MC_LATENCY)};
  assign cnt_zero   = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op_pc           <= '0;
      alu_ctrl_o      <= '0;
      alu_op_a_o      <= '0;
      alu_op_b_o      <= '0;
      alu_is_branch_o <= 1'b0;
      a_pc_o          <= '0;
      a_result        <= '0;
      a_br_en         <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      // accept is only possible in IDLE or on a completing DONE, so one capture serves both
      if (accept) begin
        op_pc           <= d_pc;
        alu_ctrl_o      <= d_alu_ctrl;
        alu_op_a_o      <= d_op_a;
        alu_op_b_o      <= d_op_b;
        alu_is_branch_o <= d_is_branch;
      end
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          if (cnt_zero) begin
            a_pc_o   <= op_pc;
            a_result <= alu_result_i;
            a_br_en  <= alu_is_branch_o && alu_br_en_i;
            state    <= DONE;
          end
        end
        DONE: if (w_ready) state <= accept ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ex_stage_ctrl.md
EX_STAGE_CTRL -- requirements
Module: ex_stage_ctrl

Interface
REQ-001 SHALL have parameter MC_LATENCY, default 4, ALU cycles per multi-cycle op (legal 2..15).
REQ-002 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports d_valid in 1, d_ready out 1: decode-side op handshake.
REQ-005 SHALL have ports d_pc in 32, d_alu_ctrl in 6, d_op_a in 32, d_op_b in 32, d_is_branch in 1, d_multicycle in 1: op payload.
REQ-006 SHALL have ports alu_ctrl_o out 6, alu_op_a_o out 32, alu_op_b_o out 32, alu_is_branch_o out 1: registered drive to ALU.
REQ-007 SHALL have ports alu_result_i in 32, alu_br_en_i in 1: combinational ALU return.
REQ-008 SHALL have ports a_valid out 1, w_ready in 1: writeback-side handshake.
REQ-009 SHALL have ports a_pc_o out 32, a_result out 32, a_br_en out 1: registered result payload.
REQ-010 SHALL have ports flush in 1 (synchronous kill), busy out 1 (state != IDLE).

Function
REQ-011 SHALL implement states IDLE, EXEC, DONE.
REQ-012 d_ready SHALL be 1 when (IDLE or (DONE and w_ready)) and flush=0, else 0.
REQ-013 On edge with d_valid and d_ready: capture payload into op registers, load cnt = d_multicycle ? MC_LATENCY-1 : 0, go EXEC.
REQ-014 In EXEC with cnt != 0: decrement cnt each edge; op registers held.
REQ-015 In EXEC with cnt == 0: next edge captures alu_result_i/alu_br_en_i into a_result/a_br_en, go DONE.
REQ-016 a_valid SHALL be 1 exactly in DONE; a_pc_o, a_result, a_br_en stable while a_valid=1 and w_ready=0.
REQ-017 Single-cycle op latency: accept at edge E0, a_valid high after E1; multi-cycle: after E(MC_LATENCY).
REQ-018 In DONE with w_ready=1: transfer completes; if d_valid same cycle, accept new op and go EXEC, else IDLE.
REQ-019 In DONE with w_ready=0: remain DONE, d_ready=0 (backpressure).
REQ-020 flush=1 at an edge SHALL force IDLE, clear a_valid, discard any in-flight and same-cycle op; flush dominates all other events.
REQ-021 a_br_en SHALL be 0 when captured op had is_branch=0, regardless of alu_br_en_i.

Reset
REQ-022 reset low SHALL immediately force IDLE, cnt=0, a_valid=0, d_ready=1 (combinational from IDLE), busy=0.
REQ-023 reset low SHALL clear all op and result registers to 0 (alu_*_o, a_pc_o, a_result, a_br_en = 0).
REQ-024 Reset mid-operation SHALL abandon the op; no a_valid pulse after release until a new accept.

Configuration
REQ-025 Macro EX_STAGE_CTRL_MULTICYCLE_EN defined: d_multicycle honoured per REQ-013.
REQ-026 Macro undefined: d_multicycle ignored, cnt logic omitted, every op single-cycle; MC_LATENCY unused.

Structure
REQ-027 Shared package SHALL hold state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2), ALU control width 6, data width 32.
REQ-028 Sub-module ex_mc_counter (load/decrement/zero-flag, width 4) SHALL implement cnt; present only with macro defined.
REQ-029 ALU itself SHALL be instantiated outside this block.

Verification
REQ-030 Single-cycle: accept ADD a=5 b=7 pc=0x100 -> a_valid after 2nd edge, a_result=12, a_pc_o=0x100.
REQ-031 Multi-cycle MC_LATENCY=4: accept op, d_multicycle=1 -> busy 4 edges, a_valid after E4, d_ready=0 throughout.
REQ-032 Backpressure: w_ready=0 for 3 cycles in DONE -> a_result held 0x0000000C, d_ready=0; w_ready=1 + d_valid -> new op accepted same edge.
REQ-033 Flush: flush=1 in EXEC with cnt=2 -> IDLE next edge, a_valid never rises; flush with d_valid=1 in IDLE -> no accept.
REQ-034 Reset: reset low in DONE -> a_valid=0 and all outputs 0 immediately, no a_valid after release.
REQ-035 Macro undefined: d_multicycle=1 op -> a_valid after 2nd edge, same as single-cycle.
